// File: rtl/sc_regsequencer_pkg.sv
// ----------------------------------------------------------------------------
// sc_regsequencer_pkg : shared state encoding and sizing helper for the sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sc_regsequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLEAR   = 2'd1,
      ST_LOAD    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   function automatic int lockout_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sc_edgepend.sv
// ----------------------------------------------------------------------------
// sc_edgepend : falling-edge detector on an active-low level with a sticky request flag
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sc_edgepend (
   input  logic clk,
   input  logic rst_n,
   input  logic level_n,
   input  logic ack,
   output logic pend
);

   logic hist;
   logic armed;
   logic fall;

   // armed stays low until the level is seen released, so a press held through reset is ignored
   assign fall = armed & hist & ~level_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist  <= 1'b1;
         armed <= 1'b0;
         pend  <= 1'b0;
      end else begin
         hist  <= level_n;
         armed <= armed | level_n;
         pend  <= fall | (pend & ~ack);
      end
   end

endmodule

`default_nettype wire

// File: rtl/sc_regsequencer.sv
// ----------------------------------------------------------------------------
// sc_regsequencer : arbitrates button/auto requests into lockout-spaced clear/load strobes
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sc_regsequencer
   import sc_regsequencer_pkg::*;
#(
   parameter int PERIOD_WIDTH   = 8,
   parameter int COUNT_WIDTH    = 8,
   parameter int LOCKOUT_CYCLES = 4
) (
   input  logic                    SC_REGSEQUENCER_CLOCK_50,
   input  logic                    SC_REGSEQUENCER_RESET_InLow,
   input  logic                    SC_REGSEQUENCER_clear_InLow,
   input  logic                    SC_REGSEQUENCER_load_InLow,
   input  logic                    SC_REGSEQUENCER_auto_In,
   input  logic [PERIOD_WIDTH-1:0] SC_REGSEQUENCER_period_InBUS,
   output logic                    SC_REGSEQUENCER_clear_OutLow,
   output logic                    SC_REGSEQUENCER_load_OutLow,
   output logic                    SC_REGSEQUENCER_busy_Out,
   output logic [COUNT_WIDTH-1:0]  SC_REGSEQUENCER_loadcount_OutBUS
);

   localparam int            LW        = lockout_width(LOCKOUT_CYCLES);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

   logic                    clk;
   logic                    rst_n;
   state_t                  state;
   logic [LW-1:0]           lock_cnt;
   logic [PERIOD_WIDTH-1:0] auto_cnt;
   logic                    auto_pend;
   logic                    auto_on;
   logic                    auto_fire;
   logic                    clear_pend;
   logic                    load_pend;
   logic                    clear_ack;
   logic                    load_ack;

   assign clk       = SC_REGSEQUENCER_CLOCK_50;
   assign rst_n     = SC_REGSEQUENCER_RESET_InLow;
   assign clear_ack = (state == ST_CLEAR);
   assign load_ack  = (state == ST_LOAD);

   sc_edgepend u_clear_pend (
      .clk     (clk),
      .rst_n   (rst_n),
      .level_n (SC_REGSEQUENCER_clear_InLow),
      .ack     (clear_ack),
      .pend    (clear_pend)
   );

   sc_edgepend u_load_pend (
      .clk     (clk),
      .rst_n   (rst_n),
      .level_n (SC_REGSEQUENCER_load_InLow),
      .ack     (load_ack),
      .pend    (load_pend)
   );

   // A clear restarts the auto period, so it suppresses any expiry in that same cycle
   assign auto_on   = SC_REGSEQUENCER_auto_In & (SC_REGSEQUENCER_period_InBUS != '0);
   assign auto_fire = auto_on & ~clear_ack & (auto_cnt <= PERIOD_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto_cnt  <= SC_REGSEQUENCER_period_InBUS;
         auto_pend <= 1'b0;
      end else if (!auto_on) begin
         auto_cnt  <= SC_REGSEQUENCER_period_InBUS;
         auto_pend <= 1'b0;
      end else begin
         if (clear_ack || auto_fire) begin
            auto_cnt <= SC_REGSEQUENCER_period_InBUS;
         end else begin
            auto_cnt <= auto_cnt - PERIOD_WIDTH'(1);
         end
         auto_pend <= auto_fire | (auto_pend & ~load_ack);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                            <= ST_IDLE;
         lock_cnt                         <= '0;
         SC_REGSEQUENCER_clear_OutLow     <= 1'b1;
         SC_REGSEQUENCER_load_OutLow      <= 1'b1;
         SC_REGSEQUENCER_busy_Out         <= 1'b0;
         SC_REGSEQUENCER_loadcount_OutBUS <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clear_pend) begin
                  state                        <= ST_CLEAR;
                  SC_REGSEQUENCER_clear_OutLow <= 1'b0;
                  SC_REGSEQUENCER_busy_Out     <= 1'b1;
               end else if (load_pend || auto_pend) begin
                  state                       <= ST_LOAD;
                  SC_REGSEQUENCER_load_OutLow <= 1'b0;
                  SC_REGSEQUENCER_busy_Out    <= 1'b1;
               end
            end
            ST_CLEAR: begin
               state                            <= ST_LOCKOUT;
               lock_cnt                         <= LOCK_LAST;
               SC_REGSEQUENCER_clear_OutLow     <= 1'b1;
               SC_REGSEQUENCER_loadcount_OutBUS <= '0;
            end
            ST_LOAD: begin
               state                            <= ST_LOCKOUT;
               lock_cnt                         <= LOCK_LAST;
               SC_REGSEQUENCER_load_OutLow      <= 1'b1;
               SC_REGSEQUENCER_loadcount_OutBUS <= SC_REGSEQUENCER_loadcount_OutBUS + COUNT_WIDTH'(1);
            end
            ST_LOCKOUT: begin
               if (lock_cnt == '0) begin
                  state                    <= ST_IDLE;
                  SC_REGSEQUENCER_busy_Out <= 1'b0;
               end else begin
                  lock_cnt <= lock_cnt - LW'(1);
               end
            end
            default: begin
               state                        <= ST_IDLE;
               SC_REGSEQUENCER_clear_OutLow <= 1'b1;
               SC_REGSEQUENCER_load_OutLow  <= 1'b1;
               SC_REGSEQUENCER_busy_Out     <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sc_regsequencer.sv
// ----------------------------------------------------------------------------
// tb_sc_regsequencer : directed and random stimulus against a timing-rule reference model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sc_regsequencer;

   localparam int LOCK = 4;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       clr_n   = 1'b1;
   logic       ld_n    = 1'b1;
   logic       auto_en = 1'b0;
   logic [7:0] period  = 8'd0;
   logic       clr_o;
   logic       ld_o;
   logic       busy_o;
   logic [7:0] cnt_o;

   always #5 clk = ~clk;

   sc_regsequencer dut (
      .SC_REGSEQUENCER_CLOCK_50         (clk),
      .SC_REGSEQUENCER_RESET_InLow      (rst_n),
      .SC_REGSEQUENCER_clear_InLow      (clr_n),
      .SC_REGSEQUENCER_load_InLow       (ld_n),
      .SC_REGSEQUENCER_auto_In          (auto_en),
      .SC_REGSEQUENCER_period_InBUS     (period),
      .SC_REGSEQUENCER_clear_OutLow     (clr_o),
      .SC_REGSEQUENCER_load_OutLow      (ld_o),
      .SC_REGSEQUENCER_busy_Out         (busy_o),
      .SC_REGSEQUENCER_loadcount_OutBUS (cnt_o)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: strobes are events on a cycle timeline, spaced by LOCK+2
   int n, last_s, last_kind, ai, cnt_m;
   int m_loads = 0, d_loads = 0, d_clears = 0;
   bit pc, pl, pa, prev_c, prev_l;
   bit exp_clr, exp_ld, exp_busy;

   task automatic model_reset();
      n = 0; last_s = -100; last_kind = 0; ai = 0; cnt_m = 0;
      pc = 0; pl = 0; pa = 0; prev_c = 0; prev_l = 0;
      exp_clr = 1; exp_ld = 1; exp_busy = 0;
   endtask

   task automatic model_step();
      bit fall_c, fall_l, en, reload, fire;
      int kind_new;
      n++;
      fall_c = prev_c && (clr_n == 1'b0);
      fall_l = prev_l && (ld_n == 1'b0);
      prev_c = (clr_n == 1'b1);
      prev_l = (ld_n == 1'b1);
      en = auto_en && (period != 8'd0);
      kind_new = 0;
      if (n >= last_s + LOCK + 2) begin
         if (pc) kind_new = 1;
         else if (pl || pa) kind_new = 2;
      end
      reload = 0;
      if (last_s == n - 1) begin
         if (last_kind == 1) begin pc = 0; cnt_m = 0; reload = 1; end
         else begin pl = 0; pa = 0; cnt_m = (cnt_m + 1) % 256; end
      end
      fire = 0;
      if (!en) begin ai = 0; pa = 0; end
      else if (reload) ai = 0;
      else begin
         ai++;
         if (ai >= int'(period)) begin fire = 1; ai = 0; end
      end
      if (fire) pa = 1;
      if (fall_c) pc = 1;
      if (fall_l) pl = 1;
      if (kind_new != 0) begin
         last_s = n; last_kind = kind_new;
         if (kind_new == 2) m_loads++;
      end
      exp_clr  = (kind_new != 1);
      exp_ld   = (kind_new != 2);
      exp_busy = (last_kind != 0) && (n <= last_s + LOCK);
   endtask

   task automatic check_outputs();
      total++;
      assert (clr_o === exp_clr) else begin bad++; $error("FAIL clear_strobe cyc=%0d got=%b exp=%b", n, clr_o, exp_clr); end
      total++;
      assert (ld_o === exp_ld) else begin bad++; $error("FAIL load_strobe cyc=%0d got=%b exp=%b", n, ld_o, exp_ld); end
      total++;
      assert (busy_o === exp_busy) else begin bad++; $error("FAIL busy cyc=%0d got=%b exp=%b", n, busy_o, exp_busy); end
      total++;
      assert (cnt_o === 8'(cnt_m)) else begin bad++; $error("FAIL loadcount cyc=%0d got=%0d exp=%0d", n, cnt_o, cnt_m); end
      total++;
      assert (!(clr_o === 1'b0 && ld_o === 1'b0)) else begin bad++; $error("FAIL mutex cyc=%0d clr=%b ld=%b", n, clr_o, ld_o); end
      if (ld_o === 1'b0) d_loads++;
      if (clr_o === 1'b0) d_clears++;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      total++;
      assert (got === exp_v) else begin bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp_v); end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int bl, bc, mbl, guard;
      model_reset();

      // Reset with both buttons held low, released later
      clr_n = 1'b0; ld_n = 1'b0;
      #12;
      check_val("rst_clear", clr_o, 1);
      check_val("rst_load", ld_o, 1);
      check_val("rst_busy", busy_o, 0);
      check_val("rst_count", cnt_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) tick();
      check_val("held_through_reset", d_loads + d_clears, 0);

      // Single load press
      clr_n = 1'b1; ld_n = 1'b1;
      repeat (3) tick();
      bl = d_loads;
      ld_n = 1'b0; tick(); ld_n = 1'b1;
      repeat (10) tick();
      check_val("single_load", d_loads - bl, 1);
      check_val("count_one", cnt_o, 1);

      // Clear and load together: clear first, load after lockout
      bl = d_loads; bc = d_clears;
      clr_n = 1'b0; ld_n = 1'b0; tick();
      clr_n = 1'b1; ld_n = 1'b1;
      repeat (14) tick();
      check_val("simul_clears", d_clears - bc, 1);
      check_val("simul_loads", d_loads - bl, 1);
      check_val("simul_count", cnt_o, 1);

      // Periodic auto-load, then period forced to zero
      period = 8'd10; tick();
      auto_en = 1'b1; bl = d_loads;
      repeat (101) tick();
      check_val("auto_loads", d_loads - bl, 10);
      period = 8'd0; bl = d_loads;
      repeat (30) tick();
      check_val("auto_off_loads", d_loads - bl, 0);
      auto_en = 1'b0; tick();

      // Three presses during lockout merge into one extra load
      bl = d_loads;
      ld_n = 1'b0; tick(); ld_n = 1'b1; tick();
      repeat (3) begin ld_n = 1'b0; tick(); ld_n = 1'b1; tick(); end
      repeat (12) tick();
      check_val("lockout_merge", d_loads - bl, 2);

      // 256 loads after a clear wrap the counter back to zero
      clr_n = 1'b0; tick(); clr_n = 1'b1;
      repeat (8) tick();
      period = 8'd6; tick();
      auto_en = 1'b1;
      mbl = m_loads; guard = 0;
      while ((m_loads - mbl) < 256 && guard < 4000) begin tick(); guard++; end
      check_val("wrap_reached", guard < 4000, 1);
      auto_en = 1'b0;
      repeat (2) tick();
      check_val("count_wrap", cnt_o, 0);

      // Random mix of buttons, auto enable and period
      period = 8'd0; tick();
      for (int i = 0; i < 600; i++) begin
         int r;
         if ($urandom_range(0, 7) == 0) clr_n = ~clr_n;
         if ($urandom_range(0, 3) == 0) ld_n = ~ld_n;
         r = $urandom_range(0, 49);
         if (r == 0) auto_en = ~auto_en;
         else if (r < 4 && !auto_en) period = 8'($urandom_range(0, 15));
         tick();
      end

      // Reset asserted during a load strobe
      auto_en = 1'b0; clr_n = 1'b1; ld_n = 1'b1;
      repeat (20) tick();
      ld_n = 1'b0; tick(); tick();
      check_val("strobe_before_reset", ld_o, 0);
      rst_n = 1'b0;
      #1;
      check_val("async_load_release", ld_o, 1);
      check_val("async_clear", clr_o, 1);
      check_val("async_busy", busy_o, 0);
      check_val("async_count", cnt_o, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      bl = d_loads;
      repeat (20) tick();
      check_val("no_strobe_after_reset", d_loads - bl, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sc_regsequencer.md
Name: sc_regsequencer

Overview:
- Controller that sequences the general register's clear/load strobes from two debounced active-low push-button levels plus an optional autonomous periodic load.
- Sits between the SC_DEBOUNCE1 outputs and the SC_RegGENERAL clear/load inputs, replacing the ad-hoc state machine.
- Arbitrates clear vs load (clear wins), converts levels to single-cycle strobes, and enforces a lockout gap between strobes.

Parameters:
- PERIOD_WIDTH, 8, width of the auto-load period input and its down-counter.
- COUNT_WIDTH, 8, width of the issued-load counter.
- LOCKOUT_CYCLES, 4, idle cycles after every strobe before the next may issue (>=1).

Ports:
- SC_REGSEQUENCER_CLOCK_50  in  1  system clock.
- SC_REGSEQUENCER_RESET_InLow  in  1  reset, asynchronous, active-low.
- SC_REGSEQUENCER_clear_InLow  in  1  debounced clear button level, active-low.
- SC_REGSEQUENCER_load_InLow  in  1  debounced load button level, active-low.
- SC_REGSEQUENCER_auto_In  in  1  enable periodic auto-load.
- SC_REGSEQUENCER_period_InBUS  in  PERIOD_WIDTH  auto-load period in cycles; 0 = auto disabled.
- SC_REGSEQUENCER_clear_OutLow  out  1  one-cycle clear strobe to register, active-low.
- SC_REGSEQUENCER_load_OutLow  out  1  one-cycle load strobe to register, active-low.
- SC_REGSEQUENCER_busy_Out  out  1  high while in CLEAR, LOAD or LOCKOUT.
- SC_REGSEQUENCER_loadcount_OutBUS  out  COUNT_WIDTH  loads issued since last clear/reset.

Behaviour:
- Reset (async, RESET_InLow=0):
  - clear_OutLow=1, load_OutLow=1, busy=0, loadcount=0.
  - State IDLE; pending flags 0; edge-detect history regs 1; auto counter loaded from period.
- Edge detect:
  - Falling edge = history & ~input.
  - At a falling edge the pending flag sets. Pending depth is 1; repeated edges while pending are merged.
  - A button held low through reset release never triggers.
- Auto timer:
  - When auto_In=1 and period!=0, the counter decrements each cycle. At 1 it sets auto_pend and reloads from period, giving one request per period cycles.
  - When auto_In=0 or period=0: counter holds reload value, auto_pend cleared.
- FSM (registered outputs decoded from state):
  - IDLE:
    - clear_pend -> CLEAR.
    - else (load_pend | auto_pend) -> LOAD.
    - else stay IDLE.
  - CLEAR:
    - clear_OutLow=0 for exactly 1 cycle.
    - Clears clear_pend, resets loadcount to 0, reloads auto counter.
    - -> LOCKOUT.
  - LOAD:
    - load_OutLow=0 for exactly 1 cycle.
    - Clears load_pend and auto_pend (merged into one load).
    - loadcount+1, wraps modulo 2^COUNT_WIDTH.
    - -> LOCKOUT.
  - LOCKOUT:
    - Stays exactly LOCKOUT_CYCLES cycles, then -> IDLE.
    - Pending flags still capture new requests.
- Latency: input first sampled low at edge k -> pend set at edge k -> strobe low in the cycle after edge k+1, i.e. 2 edges, when IDLE.
- Strobe spacing: minimum spacing between strobes is 1+LOCKOUT_CYCLES+1 cycles.
- Simultaneous events:
  - Clear and load in the same cycle: CLEAR first, then LOAD after lockout.
  - Auto expiry coincident with a load button press: a single LOAD.
- Mutual exclusion: clear_OutLow and load_OutLow are never both 0.
- Reset mid-operation: strobe deasserts immediately (async); the pending request is discarded.

Decomposition:
- Package sc_regsequencer_pkg:
  - State enum IDLE/CLEAR/LOAD/LOCKOUT (2-bit).
  - Lockout counter width derived via clog2(LOCKOUT_CYCLES+1).
- Sub-module sc_edgepend: falling-edge detect plus set/clear pending flag, async active-low reset. Instantiated twice (clear, load).

Test Plan:
- Reset release with both buttons held low -> no strobes for 50 cycles, outputs 1, loadcount=0.
- Load falling edge at cycle 10 (auto=0) -> load_OutLow=0 only in cycle 12, busy=1 cycles 12–16, loadcount=1.
- Clear and load fall in the same cycle 20 -> clear strobe at 22, load strobe at 28, loadcount=1, no overlap.
- auto=1, period=10 for 100 cycles -> exactly 10 load strobes, 10 cycles apart, loadcount=10. Then period=0 -> no further strobes.
- Load pressed 3 times during lockout -> exactly one extra load strobe after lockout. Also 256 loads -> loadcount wraps to 0.
- Assert reset in the cycle load_OutLow=0 -> load_OutLow returns to 1 within the same cycle, state IDLE, no strobe after release.
